scroll_sequencer: RTL and testbench
===================================

// Module: scroll_sequencer
// PURPOSE
//  Game-phase controller sequencing the scrolling-object movers (trees, road edges, rival cars).
//  Generates their move_allow, restart_enable, slow_pulse, fast_pulse and boost-gated enter from one FSM.
//  Sits between the keyboard/collision logic and every mover instance, so all scrolling objects share
//  one timebase and freeze, restart and boost together.
// PARAMETERS
//  SLOW_DIV          8    frames per slow_pulse (mover speed update rate), >=1
//  FAST_DIV          2    frames per fast_pulse while boost active, >=1
//  COUNTDOWN_FRAMES  90   frames spent in COUNTDOWN before RUN
//  CRASH_FRAMES      60   frames movers stay frozen after a collision
//  BOOST_FRAMES      15   frames a granted boost lasts
//  BOOST_COOLDOWN    120  frames after boost end before next grant
// PORTS
//  clk               in   1  system clock
//  resetN            in   1  async active-low reset
//  startOfFrame      in   1  1-clk pulse per frame
//  enter_is_pressed  in   1  start request (IDLE/FINISH) and boost request (RUN), level
//  collision         in   1  player hit obstacle, level, sampled every clk
//  finish_line       in   1  player crossed finish, level
//  restart_req       in   1  user restart, level, sampled every clk
//  move_allow        out  1  movers may integrate position/speed
//  restart_enable    out  1  1-clk pulse: movers reload initial position/speed
//  slow_pulse        out  1  1-clk pulse every SLOW_DIV frames, RUN only
//  fast_pulse        out  1  1-clk pulse every FAST_DIV frames, boost only
//  boost_grant       out  1  level: gated enter for movers (high during boost)
//  game_state        out  3  encoded FSM state for display/HUD
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; move_allow, restart_enable, slow_pulse, fast_pulse, boost_grant = 0.
//  States/encoding: IDLE=0, COUNTDOWN=1, RUN=2, CRASH=3, FINISH=4. All outputs registered (1-clk latency).
//  Frame counter (frame_cnt) advances only on startOfFrame; state timers count frames, not clocks.
//  IDLE: enter_is_pressed -> COUNTDOWN, restart_enable pulses on the transition clk.
//  COUNTDOWN: after COUNTDOWN_FRAMES frames -> RUN; move_allow=0. Slow/fast dividers cleared on entry to RUN.
//  RUN: move_allow=1. slow_pulse on the startOfFrame clk when slow_div_cnt==SLOW_DIV-1 (then wraps to 0).
//   finish_line -> FINISH; else collision -> CRASH (finish wins if both in same clk).
//  CRASH: move_allow=0, boost cancelled, cooldown forced to BOOST_COOLDOWN; after CRASH_FRAMES frames -> RUN.
//  FINISH: move_allow=0; enter_is_pressed rising edge -> COUNTDOWN with restart_enable pulse.
//  restart_req (any state, highest priority): restart_enable pulse, -> IDLE, all timers/boost cleared.
//  Boost: in RUN, enter_is_pressed with boost idle and cooldown==0 -> boost_grant=1 for BOOST_FRAMES frames,
//   fast_pulse on startOfFrame when fast_div_cnt==FAST_DIV-1; on expiry cooldown=BOOST_COOLDOWN, counts down per frame.
//   Holding enter does not retrigger until cooldown reaches 0; boost_grant/fast_pulse never high outside RUN.
//  slow_pulse and fast_pulse may coincide in one clk; both asserted.
//  Enter edge detect uses a registered copy of enter_is_pressed (cleared by reset).
//  Counters: 8-bit for frame timers (parameters must be <=255), 4-bit dividers; saturate at 0, no underflow.
//  resetN mid-operation: immediate return to reset values, no restart_enable pulse emitted.
// STRUCTURE
//  Package game_pkg: typedef enum logic[2:0] game_state_t {IDLE,COUNTDOWN,RUN,CRASH,FINISH};
//   shared FRAME_RATE constant; game_state port typed game_state_t by consumers.
//  Sub-module frame_divider (parameter DIV; inputs clk,resetN,clear,enable,startOfFrame; output pulse)
//   instantiated twice: slow (enable=RUN) and fast (enable=boost active).
//  FSM, boost/cooldown timers and edge detect live in the top module.
// TESTING
//  1 Reset, enter 1 clk -> restart_enable 1 clk, state COUNTDOWN; after 90 frames state RUN, move_allow=1.
//  2 RUN 80 frames, SLOW_DIV=8 -> exactly 10 slow_pulse, each 1 clk, aligned to startOfFrame+1 clk.
//  3 RUN, enter held 300 frames -> boost_grant 15 frames, 7-8 fast_pulse, no regrant for 120 frames, then regrant.
//  4 collision during boost -> CRASH, boost_grant=0 next clk, move_allow=0 for 60 frames, back to RUN, cooldown 120.
//  5 collision and finish_line same clk in RUN -> FINISH; enter edge -> COUNTDOWN with restart_enable pulse.
//  6 restart_req in CRASH mid-timer -> restart_enable pulse, IDLE; resetN low in RUN -> all outputs 0 async.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-phase types, counter widths and timer helper for the scrolling-object sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  // FSM encoding is visible on the HUD port, so the values are pinned explicitly
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    RUN       = 3'd2,
    CRASH     = 3'd3,
    FINISH    = 3'd4
  } game_state_t;

  // nominal display frame rate, handy for converting seconds to frame counts
  localparam int FRAME_RATE = 60;

  // frame timers are 8 bits wide, pulse dividers 4 bits
  localparam int TIMER_W = 8;
  localparam int DIV_W   = 4;

  // saturating decrement: a timer parked at zero stays at zero
  function automatic logic [TIMER_W-1:0] timer_dec(input logic [TIMER_W-1:0] t);
    return (t == '0) ? '0 : t - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/scroll_sequencer_if.sv
// Bundle of game-control inputs and mover-timebase outputs around the scroll sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-clock pulses.
interface scroll_sequencer_if;
  import game_pkg::*;

  // controls from keyboard / collision logic
  logic        startOfFrame;
  logic        enter_is_pressed;
  logic        collision;
  logic        finish_line;
  logic        restart_req;

  // timebase shared by every mover instance
  logic        move_allow;
  logic        restart_enable;
  logic        slow_pulse;
  logic        fast_pulse;
  logic        boost_grant;
  game_state_t game_state;

  // sequencer side
  modport master (
    input  startOfFrame, enter_is_pressed, collision, finish_line, restart_req,
    output move_allow, restart_enable, slow_pulse, fast_pulse, boost_grant, game_state
  );

  // mover / HUD side
  modport slave (
    output startOfFrame, enter_is_pressed, collision, finish_line, restart_req,
    input  move_allow, restart_enable, slow_pulse, fast_pulse, boost_grant, game_state
  );

endinterface

// File: rtl/frame_divider.sv
// Emits a one-clock pulse every DIV enabled frames.
// Latency: pulse registered, one clock after the qualifying startOfFrame.
// Backpressure: none; clear wins over enable and drops any pending pulse.
module frame_divider #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  input  logic startOfFrame,
  output logic pulse
);
  import game_pkg::*;

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt;

  // count enabled frames, wrap on the last one and fire the pulse
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (enable && startOfFrame) begin
        if (cnt == LAST) begin
          cnt   <= '0;
          pulse <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/scroll_sequencer.sv
// Game-phase FSM giving all scrolling movers one shared move/restart/boost timebase.
// Latency: every output registered, one clock after the input that causes it.
// Backpressure: none; restart_req overrides everything, finish beats collision.
module scroll_sequencer #(
  parameter int SLOW_DIV         = 8,
  parameter int FAST_DIV         = 2,
  parameter int COUNTDOWN_FRAMES = 90,
  parameter int CRASH_FRAMES     = 60,
  parameter int BOOST_FRAMES     = 15,
  parameter int BOOST_COOLDOWN   = 120
) (
  input logic          clk,
  input logic          resetN,
  scroll_sequencer_if.master bus
);
  import game_pkg::*;

  localparam logic [TIMER_W-1:0] CD_LOAD    = TIMER_W'(COUNTDOWN_FRAMES);
  localparam logic [TIMER_W-1:0] CRASH_LOAD = TIMER_W'(CRASH_FRAMES);
  localparam logic [TIMER_W-1:0] BOOST_LOAD = TIMER_W'(BOOST_FRAMES);
  localparam logic [TIMER_W-1:0] COOL_LOAD  = TIMER_W'(BOOST_COOLDOWN);

  game_state_t        state, state_nxt;
  logic [TIMER_W-1:0] state_timer, state_timer_nxt;
  logic [TIMER_W-1:0] boost_timer, boost_timer_nxt;
  logic [TIMER_W-1:0] cooldown, cooldown_nxt;
  logic               boost_q, boost_nxt;
  logic               enter_q;
  logic               move_allow_q;
  logic               restart_q, restart_nxt;

  logic sof;
  logic enter;
  logic enter_rise;
  logic run_stay;
  logic slow_en, slow_clr;
  logic fast_en, fast_clr;

  assign sof        = bus.startOfFrame;
  assign enter      = bus.enter_is_pressed;
  assign enter_rise = enter && !enter_q;
  // dividers and boost only tick while RUN persists through this clock,
  // so no pulse or grant can land in the same clock as a state change away from RUN
  assign run_stay   = (state == RUN) && (state_nxt == RUN);

  // state register plus all timers and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      state_timer  <= '0;
      boost_timer  <= '0;
      cooldown     <= '0;
      boost_q      <= 1'b0;
      enter_q      <= 1'b0;
      move_allow_q <= 1'b0;
      restart_q    <= 1'b0;
    end else begin
      state        <= state_nxt;
      state_timer  <= state_timer_nxt;
      boost_timer  <= boost_timer_nxt;
      cooldown     <= cooldown_nxt;
      boost_q      <= boost_nxt;
      enter_q      <= enter;
      move_allow_q <= (state_nxt == RUN);
      restart_q    <= restart_nxt;
    end
  end

  // phase transitions and the countdown/crash frame timer
  always_comb begin
    state_nxt       = state;
    state_timer_nxt = state_timer;
    restart_nxt     = 1'b0;
    if (bus.restart_req) begin
      state_nxt       = IDLE;
      state_timer_nxt = '0;
      restart_nxt     = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (enter) begin
            state_nxt       = COUNTDOWN;
            state_timer_nxt = CD_LOAD;
            restart_nxt     = 1'b1;
          end
        end
        COUNTDOWN: begin
          if (sof) begin
            if (state_timer <= TIMER_W'(1)) begin
              state_nxt       = RUN;
              state_timer_nxt = '0;
            end else begin
              state_timer_nxt = timer_dec(state_timer);
            end
          end
        end
        RUN: begin
          if (bus.finish_line) begin
            state_nxt = FINISH;
          end else if (bus.collision) begin
            state_nxt       = CRASH;
            state_timer_nxt = CRASH_LOAD;
          end
        end
        CRASH: begin
          if (sof) begin
            if (state_timer <= TIMER_W'(1)) begin
              state_nxt       = RUN;
              state_timer_nxt = '0;
            end else begin
              state_timer_nxt = timer_dec(state_timer);
            end
          end
        end
        FINISH: begin
          if (enter_rise) begin
            state_nxt       = COUNTDOWN;
            state_timer_nxt = CD_LOAD;
            restart_nxt     = 1'b1;
          end
        end
        default: begin
          state_nxt       = IDLE;
          state_timer_nxt = '0;
        end
      endcase
    end
  end

  // boost grant, boost duration and post-boost cooldown
  always_comb begin
    boost_nxt       = boost_q;
    boost_timer_nxt = boost_timer;
    cooldown_nxt    = cooldown;
    if (bus.restart_req) begin
      boost_nxt       = 1'b0;
      boost_timer_nxt = '0;
      cooldown_nxt    = '0;
    end else if (state == CRASH || state_nxt == CRASH) begin
      // held at full cooldown for the whole crash, including the exit clock
      boost_nxt       = 1'b0;
      boost_timer_nxt = '0;
      cooldown_nxt    = COOL_LOAD;
    end else if (boost_q) begin
      if (!run_stay) begin
        boost_nxt       = 1'b0;
        boost_timer_nxt = '0;
      end else if (sof) begin
        if (boost_timer <= TIMER_W'(1)) begin
          boost_nxt       = 1'b0;
          boost_timer_nxt = '0;
          cooldown_nxt    = COOL_LOAD;
        end else begin
          boost_timer_nxt = timer_dec(boost_timer);
        end
      end
    end else begin
      if (run_stay && enter && cooldown == '0) begin
        boost_nxt       = 1'b1;
        boost_timer_nxt = BOOST_LOAD;
      end else if (sof) begin
        cooldown_nxt = timer_dec(cooldown);
      end
    end
  end

  assign slow_clr = (state != RUN);
  assign slow_en  = run_stay;
  assign fast_clr = !boost_q;
  assign fast_en  = run_stay && boost_q && boost_nxt;

  frame_divider #(.DIV(SLOW_DIV)) u_slow_div (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (slow_clr),
    .enable       (slow_en),
    .startOfFrame (sof),
    .pulse        (bus.slow_pulse)
  );

  frame_divider #(.DIV(FAST_DIV)) u_fast_div (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (fast_clr),
    .enable       (fast_en),
    .startOfFrame (sof),
    .pulse        (bus.fast_pulse)
  );

  assign bus.move_allow     = move_allow_q;
  assign bus.restart_enable = restart_q;
  assign bus.boost_grant    = boost_q;
  assign bus.game_state     = state;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for the scroll sequencer: phases, dividers, boost, crash, finish, restart, reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_scroll_sequencer;
  import game_pkg::*;

  localparam int FRAME_CLKS      = 4;
  localparam int WATCHDOG_FRAMES = FRAME_RATE * 40;

  logic clk;
  logic resetN;

  scroll_sequencer_if bus ();

  scroll_sequencer dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int slow_cnt, fast_cnt, misalign, fast_orphan, move_hi, grant_sofs, frame_idx;
  logic grant_prev;
  int rise_q[$];
  int fall_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic clear_mon();
    slow_cnt = 0; fast_cnt = 0; misalign = 0; fast_orphan = 0;
    move_hi = 0; grant_sofs = 0; frame_idx = 0;
    rise_q.delete();
    fall_q.delete();
  endtask

  // one clock: remember the sof sampled at this edge, then observe the outputs it produced
  task automatic step();
    logic sof_s;
    sof_s = bus.startOfFrame;
    @(posedge clk);
    #1;
    if (bus.slow_pulse) begin
      slow_cnt++;
      if (!sof_s) misalign++;
    end
    if (bus.fast_pulse) begin
      fast_cnt++;
      if (!sof_s) misalign++;
      if (!bus.boost_grant) fast_orphan++;
    end
    if (bus.move_allow) move_hi++;
    if (bus.boost_grant && !grant_prev) rise_q.push_back(frame_idx);
    if (!bus.boost_grant && grant_prev) fall_q.push_back(frame_idx);
    if (sof_s && grant_prev) grant_sofs++;
    grant_prev = bus.boost_grant;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_idx++;
      bus.startOfFrame = 1'b1;
      step();
      bus.startOfFrame = 1'b0;
      repeat (FRAME_CLKS - 1) step();
    end
  endtask

  initial begin
    #(WATCHDOG_FRAMES * FRAME_CLKS * 10);
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN               = 1'b0;
    bus.startOfFrame     = 1'b0;
    bus.enter_is_pressed = 1'b0;
    bus.collision        = 1'b0;
    bus.finish_line      = 1'b0;
    bus.restart_req      = 1'b0;
    grant_prev           = 1'b0;
    clear_mon();

    // reset values
    repeat (3) step();
    check("rst_state",   bus.game_state, IDLE);
    check("rst_move",    bus.move_allow, 0);
    check("rst_restart", bus.restart_enable, 0);
    check("rst_slow",    bus.slow_pulse, 0);
    check("rst_fast",    bus.fast_pulse, 0);
    check("rst_grant",   bus.boost_grant, 0);
    resetN = 1'b1;
    step();
    check("idle_hold", bus.game_state, IDLE);

    // 1: start from IDLE, 90-frame countdown
    bus.enter_is_pressed = 1'b1;
    step();
    bus.enter_is_pressed = 1'b0;
    check("t1_state_cd",   bus.game_state, COUNTDOWN);
    check("t1_restart_hi", bus.restart_enable, 1);
    check("t1_move_cd",    bus.move_allow, 0);
    step();
    check("t1_restart_lo", bus.restart_enable, 0);
    run_frames(89);
    check("t1_cd_at_89", bus.game_state, COUNTDOWN);
    check("t1_move_89",  bus.move_allow, 0);
    run_frames(1);
    check("t1_run_at_90", bus.game_state, RUN);
    check("t1_move_run",  bus.move_allow, 1);

    // 2: 80 RUN frames -> 10 single-clock slow pulses, one clock after sof
    clear_mon();
    run_frames(80);
    check("t2_slow_cnt",  slow_cnt, 10);
    check("t2_misalign",  misalign, 0);
    check("t2_no_fast",   fast_cnt, 0);
    check("t2_no_grant",  rise_q.size(), 0);

    // 3: enter held 300 frames -> grants at frames 1, 136, 271, each 15 frames, 7 fast pulses each
    clear_mon();
    bus.enter_is_pressed = 1'b1;
    run_frames(300);
    bus.enter_is_pressed = 1'b0;
    check("t3_rises",      rise_q.size(), 3);
    check("t3_rise0",      q_at(rise_q, 0), 1);
    check("t3_rise1",      q_at(rise_q, 1), 136);
    check("t3_rise2",      q_at(rise_q, 2), 271);
    check("t3_fall0",      q_at(fall_q, 0), 16);
    check("t3_fall1",      q_at(fall_q, 1), 151);
    check("t3_fall2",      q_at(fall_q, 2), 286);
    check("t3_grant_sofs", grant_sofs, 45);
    check("t3_fast_cnt",   fast_cnt, 21);
    check("t3_fast_orph",  fast_orphan, 0);
    check("t3_misalign",   misalign, 0);

    // 4: let cooldown (106 left) drain, boost, then crash mid-boost
    clear_mon();
    run_frames(106);
    check("t4_no_early_grant", rise_q.size(), 0);
    bus.enter_is_pressed = 1'b1;
    step();
    bus.enter_is_pressed = 1'b0;
    check("t4_grant", bus.boost_grant, 1);
    run_frames(3);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    check("t4_state_crash", bus.game_state, CRASH);
    check("t4_grant_off",   bus.boost_grant, 0);
    check("t4_move_off",    bus.move_allow, 0);
    move_hi = 0;
    run_frames(59);
    check("t4_crash_59",   bus.game_state, CRASH);
    check("t4_frozen",     move_hi, 0);
    run_frames(1);
    check("t4_back_run",   bus.game_state, RUN);
    check("t4_move_back",  bus.move_allow, 1);
    bus.enter_is_pressed = 1'b1;
    run_frames(119);
    check("t4_cool_119",   bus.boost_grant, 0);
    run_frames(1);
    check("t4_cool_120",   bus.boost_grant, 1);

    // 5: finish and collision together -> FINISH; only an enter edge restarts
    bus.collision   = 1'b1;
    bus.finish_line = 1'b1;
    step();
    bus.collision   = 1'b0;
    bus.finish_line = 1'b0;
    check("t5_finish",     bus.game_state, FINISH);
    check("t5_grant_off",  bus.boost_grant, 0);
    check("t5_move_off",   bus.move_allow, 0);
    step();
    check("t5_level_hold", bus.game_state, FINISH);
    bus.enter_is_pressed = 1'b0;
    step();
    bus.enter_is_pressed = 1'b1;
    step();
    bus.enter_is_pressed = 1'b0;
    check("t5_countdown",  bus.game_state, COUNTDOWN);
    check("t5_restart",    bus.restart_enable, 1);
    step();
    check("t5_restart_lo", bus.restart_enable, 0);

    // 6: restart_req mid-crash, then async reset while running with boost
    run_frames(90);
    check("t6_run", bus.game_state, RUN);
    bus.collision = 1'b1;
    step();
    bus.collision = 1'b0;
    run_frames(20);
    check("t6_crash_mid", bus.game_state, CRASH);
    bus.restart_req = 1'b1;
    step();
    bus.restart_req = 1'b0;
    check("t6_idle",        bus.game_state, IDLE);
    check("t6_restart",     bus.restart_enable, 1);
    check("t6_move_off",    bus.move_allow, 0);
    step();
    check("t6_restart_lo",  bus.restart_enable, 0);
    check("t6_idle_stay",   bus.game_state, IDLE);
    bus.enter_is_pressed = 1'b1;
    step();
    bus.enter_is_pressed = 1'b0;
    run_frames(90);
    bus.enter_is_pressed = 1'b1;
    step();
    check("t6_pre_move",    bus.move_allow, 1);
    check("t6_pre_grant",   bus.boost_grant, 1);
    resetN = 1'b0;
    #2;
    check("t6_async_state", bus.game_state, IDLE);
    check("t6_async_move",  bus.move_allow, 0);
    check("t6_async_grant", bus.boost_grant, 0);
    check("t6_async_rst",   bus.restart_enable, 0);
    check("t6_async_fast",  bus.fast_pulse, 0);
    check("t6_async_slow",  bus.slow_pulse, 0);
    bus.enter_is_pressed = 1'b0;
    repeat (2) step();
    resetN = 1'b1;
    step();
    check("t6_post_state",  bus.game_state, IDLE);
    check("t6_post_rst",    bus.restart_enable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
